debug_tx_sched: RTL

DEBUG_TX_SCHED -- requirements
Module: debug_tx_sched

---
 rtl/debug_tx_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/debug_tx_sched.sv
// Debug message scheduler: arbitrates checkpoint and bus-snapshot requests
// and streams each one as an ASCII line to a UART transmitter.
module debug_tx_sched #(
  parameter int CRLF = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_code,
  output logic        s_ready,
  input  logic        b_valid,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_data,
  output logic        b_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] msg_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0] S_LAST = (CRLF != 0) ? 4'd4 : 4'd3;
  localparam logic [3:0] B_LAST = (CRLF != 0) ? 4'd9 : 4'd8;

  state_t      state_q, state_d;
  logic        s_full_q, s_full_d;
  logic [7:0]  s_hold_q, s_hold_d;
  logic        b_full_q, b_full_d;
  logic [15:0] b_addr_q, b_addr_d;
  logic [7:0]  b_data_q, b_data_d;
  logic        msg_is_b_q, msg_is_b_d;
  logic [15:0] msg_addr_q, msg_addr_d;
  logic [7:0]  msg_data_q, msg_data_d;
  logic [3:0]  idx_q, idx_d;
  logic        rr_b_q, rr_b_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [15:0] count_q, count_d;
  logic        grant_b;
  logic [3:0]  last_idx;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] r;
    r = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    return r;
  endfunction

  // Byte at position idx of the message; data doubles as the checkpoint code.
  function automatic logic [7:0] msg_byte(input logic is_b, input logic [15:0] addr,
                                          input logic [7:0] data, input logic [3:0] idx);
    logic [7:0] term;
    logic [7:0] r;
    term = ((CRLF != 0) && (idx == (is_b ? 4'd8 : 4'd3))) ? 8'h0D : 8'h0A;
    r = term;
    if (!is_b) begin
      case (idx)
        4'd0:    r = 8'h53;
        4'd1:    r = hex_ascii(data[7:4]);
        4'd2:    r = hex_ascii(data[3:0]);
        default: r = term;
      endcase
    end else begin
      case (idx)
        4'd0:    r = 8'h42;
        4'd1:    r = hex_ascii(addr[15:12]);
        4'd2:    r = hex_ascii(addr[11:8]);
        4'd3:    r = hex_ascii(addr[7:4]);
        4'd4:    r = hex_ascii(addr[3:0]);
        4'd5:    r = 8'h3A;
        4'd6:    r = hex_ascii(data[7:4]);
        4'd7:    r = hex_ascii(data[3:0]);
        default: r = term;
      endcase
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    s_full_d   = s_full_q;
    s_hold_d   = s_hold_q;
    b_full_d   = b_full_q;
    b_addr_d   = b_addr_q;
    b_data_d   = b_data_q;
    msg_is_b_d = msg_is_b_q;
    msg_addr_d = msg_addr_q;
    msg_data_d = msg_data_q;
    idx_d      = idx_q;
    rr_b_d     = rr_b_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    count_d    = count_q;
    grant_b    = 1'b0;
    last_idx   = msg_is_b_q ? B_LAST : S_LAST;

    case (state_q)
      IDLE: begin
        if (s_full_q || b_full_q) begin
          grant_b    = b_full_q && (!s_full_q || rr_b_q);
          msg_is_b_d = grant_b;
          msg_addr_d = b_addr_q;
          msg_data_d = grant_b ? b_data_q : s_hold_q;
          if (grant_b) b_full_d = 1'b0;
          else         s_full_d = 1'b0;
          rr_b_d     = !grant_b;
          idx_d      = 4'd0;
          state_d    = SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = grant_b ? 8'h42 : 8'h53;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == last_idx) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            count_d    = count_q + 16'd1;
          end else begin
            idx_d     = idx_q + 4'd1;
            tx_data_d = msg_byte(msg_is_b_q, msg_addr_q, msg_data_q, idx_q + 4'd1);
          end
        end
      end
    endcase

    // A grant only ever empties a full register, so it never collides with an accept.
    if (s_valid && !s_full_q) begin
      s_full_d = 1'b1;
      s_hold_d = s_code;
    end
    if (b_valid && !b_full_q) begin
      b_full_d = 1'b1;
      b_addr_d = b_addr;
      b_data_d = b_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      s_full_q   <= 1'b0;
      s_hold_q   <= 8'h00;
      b_full_q   <= 1'b0;
      b_addr_q   <= 16'h0000;
      b_data_q   <= 8'h00;
      msg_is_b_q <= 1'b0;
      msg_addr_q <= 16'h0000;
      msg_data_q <= 8'h00;
      idx_q      <= 4'd0;
      rr_b_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      s_full_q   <= s_full_d;
      s_hold_q   <= s_hold_d;
      b_full_q   <= b_full_d;
      b_addr_q   <= b_addr_d;
      b_data_q   <= b_data_d;
      msg_is_b_q <= msg_is_b_d;
      msg_addr_q <= msg_addr_d;
      msg_data_q <= msg_data_d;
      idx_q      <= idx_d;
      rr_b_q     <= rr_b_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      count_q    <= count_d;
    end
  end

  assign s_ready   = !s_full_q;
  assign b_ready   = !b_full_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = (state_q == SEND);
  assign msg_count = count_q;

endmodule
